// File: rtl/fsm_link_pkg.sv
// Shared definitions for the 2-bit symbol link: state codes, symbol type and
// the receiver's transition/output tables plus the transmitter routing rules.
package fsm_link_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_t;

  localparam state_t ST_A  = 2'b00;
  localparam state_t ST_S1 = 2'b01;
  localparam state_t ST_S2 = 2'b10;
  localparam state_t ST_B  = 2'b11;

  function automatic state_t next_state(input state_t s, input sym_t y);
    state_t n;
    n = ST_A;
    case (s)
      ST_A:    n = y;
      ST_S1: begin
        case (y)
          2'd0:    n = ST_A;
          2'd1:    n = ST_B;
          2'd2:    n = ST_S1;
          default: n = ST_B;
        endcase
      end
      ST_S2: begin
        case (y)
          2'd0:    n = ST_S1;
          2'd1:    n = ST_B;
          2'd2:    n = ST_S2;
          default: n = ST_A;
        endcase
      end
      default: begin
        case (y)
          2'd0:    n = ST_S1;
          2'd1:    n = ST_A;
          2'd2:    n = ST_A;
          default: n = ST_B;
        endcase
      end
    endcase
    return n;
  endfunction

  function automatic logic moore_out(input state_t s);
    return (s == ST_A) || (s == ST_S2);
  endfunction

  function automatic sym_t hold_sym(input state_t s);
    sym_t y;
    case (s)
      ST_A:    y = 2'd0;
      ST_S1:   y = 2'd2;
      ST_S2:   y = 2'd2;
      default: y = 2'd3;
    endcase
    return y;
  endfunction

  // Lowest direct symbol; S1->S2 and B->S2 have no direct arc and go via A first.
  function automatic sym_t hop_sym(input state_t s, input state_t t);
    sym_t y;
    y = 2'd0;
    case (s)
      ST_A: y = t;
      ST_S1: begin
        case (t)
          ST_A:    y = 2'd0;
          ST_S1:   y = 2'd2;
          ST_S2:   y = 2'd0;
          default: y = 2'd1;
        endcase
      end
      ST_S2: begin
        case (t)
          ST_A:    y = 2'd3;
          ST_S1:   y = 2'd0;
          ST_S2:   y = 2'd2;
          default: y = 2'd1;
        endcase
      end
      default: begin
        case (t)
          ST_A:    y = 2'd1;
          ST_S1:   y = 2'd0;
          ST_S2:   y = 2'd1;
          default: y = 2'd3;
        endcase
      end
    endcase
    return y;
  endfunction

endpackage

// File: rtl/fsm_route_lut.sv
// Combinational routing table: hold and hop symbols for the shadow state and
// the state the receiver will move to on a given symbol.
module fsm_route_lut
  import fsm_link_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic [1:0] i_target,
  input  logic [1:0] i_sym,
  output logic [1:0] o_hold,
  output logic [1:0] o_hop,
  output logic [1:0] o_next
);

  assign o_hold = hold_sym(i_state);
  assign o_hop  = hop_sym(i_state, i_target);
  assign o_next = next_state(i_state, i_sym);

endmodule

// File: rtl/fsm_steer_tx.sv
// Steering transmitter: tracks the receiver FSM in a shadow register, emits the
// shortest symbol sequence to each requested state and flags output mismatches.
// Handshake: a request transfers at a rising edge where req_valid && req_ready;
// req_target must stay stable while req_valid is high and req_ready is low.
module fsm_steer_tx
  import fsm_link_pkg::*;
#(
  parameter bit DESYNC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic [1:0] sym_out,
  output logic [1:0] shadow_state,
  output logic       exp_output,
  input  logic       obs_output,
  output logic       done,
  output logic       desync,
  output logic       dbg_ctrl_state
);

  localparam logic [0:0] CTRL_IDLE = 1'b0;
  localparam logic [0:0] CTRL_STEP = 1'b1;

  logic [0:0] r_ctrl;
  logic [1:0] r_shadow;
  logic [1:0] r_target;
  logic       r_done;
  logic       r_desync;

  logic [1:0] w_hold;
  logic [1:0] w_hop;
  logic [1:0] w_next;
  logic [1:0] w_sym;
  logic       w_exp;
  logic       w_mismatch;
  logic       w_accept;

  fsm_route_lut u_lut (
    .i_state  (r_shadow),
    .i_target (r_target),
    .i_sym    (w_sym),
    .o_hold   (w_hold),
    .o_hop    (w_hop),
    .o_next   (w_next)
  );

  assign w_sym      = reset ? 2'b00 :
                      ((r_ctrl == CTRL_STEP) && !r_desync) ? w_hop : w_hold;
  assign w_exp      = reset ? 1'b1 : moore_out(r_shadow);
  assign w_mismatch = DESYNC_EN && !reset && (obs_output != w_exp);
  assign req_ready  = !r_desync && !reset && (r_ctrl == CTRL_IDLE);
  assign w_accept   = req_valid && req_ready;

  // The shadow always follows the symbol on the wire, so it tracks the
  // receiver even when a step is aborted by a mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= CTRL_IDLE;
      r_shadow <= ST_A;
      r_target <= ST_A;
      r_done   <= 1'b0;
      r_desync <= 1'b0;
    end else begin
      r_shadow <= w_next;
      r_done   <= 1'b0;
      if (w_mismatch) begin
        r_desync <= 1'b1;
      end
      case (r_ctrl)
        CTRL_IDLE: begin
          if (w_accept) begin
            r_target <= req_target;
            if (req_target == r_shadow) begin
              r_done <= !w_mismatch;
            end else if (!w_mismatch) begin
              r_ctrl <= CTRL_STEP;
            end
          end
        end
        default: begin
          if (w_mismatch) begin
            r_ctrl <= CTRL_IDLE;
          end else if (w_next == r_target) begin
            r_ctrl <= CTRL_IDLE;
            r_done <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sym_out        = w_sym;
  assign shadow_state   = r_shadow;
  assign exp_output     = w_exp;
  assign done           = r_done;
  assign desync         = r_desync;
  assign dbg_ctrl_state = r_ctrl[0];

endmodule

// File: tb/tb_fsm_steer_tx.sv
// Directed bench for fsm_steer_tx with a behavioural receiver on the link.
module tb_fsm_steer_tx;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic [1:0] sym_out;
  logic [1:0] shadow_state;
  logic       exp_output;
  logic       obs_output;
  logic       done;
  logic       desync;
  logic       dbg_ctrl_state;

  int errors;
  int checks;

  logic [1:0] rx_state;
  logic       force_obs;
  logic       force_val;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fsm_steer_tx #(.DESYNC_EN(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_target     (req_target),
    .req_ready      (req_ready),
    .sym_out        (sym_out),
    .shadow_state   (shadow_state),
    .exp_output     (exp_output),
    .obs_output     (obs_output),
    .done           (done),
    .desync         (desync),
    .dbg_ctrl_state (dbg_ctrl_state)
  );

  // Independent receiver model written straight from the link transition table.
  function automatic logic [1:0] rx_next(input logic [1:0] s, input logic [1:0] y);
    logic [1:0] tbl [0:15];
    tbl = '{2'd0, 2'd1, 2'd2, 2'd3,
            2'd0, 2'd3, 2'd1, 2'd3,
            2'd1, 2'd3, 2'd2, 2'd0,
            2'd1, 2'd0, 2'd0, 2'd3};
    return tbl[{s, y}];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) rx_state <= 2'd0;
    else       rx_state <= rx_next(rx_state, sym_out);
  end

  assign obs_output = force_obs ? force_val :
                      ((rx_state == 2'd0) || (rx_state == 2'd2));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_target = 2'd0;
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++; if (sym_out !== 2'b00) begin errors++; $display("FAIL reset_sym got=%b exp=00", sym_out); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sym_out !== 2'b00) begin errors++; $display("FAIL idle_sym[%0d] got=%b exp=00", i, sym_out); end
      checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL idle_shadow[%0d] got=%b exp=00", i, shadow_state); end
      checks++; if (exp_output !== 1'b1) begin errors++; $display("FAIL idle_exp[%0d] got=%b exp=1", i, exp_output); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d] got=%b exp=1", i, req_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done[%0d] got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_single_hop();
    req_valid = 1'b1; req_target = 2'd3;
    step();
    req_valid = 1'b0;
    checks++; if (sym_out !== 2'b11) begin errors++; $display("FAIL hop_a_b_sym got=%b exp=11", sym_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hop_a_b_ready got=%b exp=0", req_ready); end
    checks++; if (dbg_ctrl_state !== 1'b1) begin errors++; $display("FAIL hop_a_b_ctrl got=%b exp=1", dbg_ctrl_state); end
    step();
    checks++; if (shadow_state !== 2'b11) begin errors++; $display("FAIL hop_a_b_shadow got=%b exp=11", shadow_state); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hop_a_b_done got=%b exp=1", done); end
    checks++; if (sym_out !== 2'b11) begin errors++; $display("FAIL hold_b_sym got=%b exp=11", sym_out); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hop_a_b_done_pulse got=%b exp=0", done); end
    checks++; if (sym_out !== 2'b11) begin errors++; $display("FAIL hold_b_sym2 got=%b exp=11", sym_out); end
  endtask

  task automatic test_two_hop();
    req_valid = 1'b1; req_target = 2'd2;
    step();
    req_valid = 1'b0;
    checks++; if (sym_out !== 2'b01) begin errors++; $display("FAIL b_s2_sym1 got=%b exp=01", sym_out); end
    step();
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL b_s2_mid_shadow got=%b exp=00", shadow_state); end
    checks++; if (sym_out !== 2'b10) begin errors++; $display("FAIL b_s2_sym2 got=%b exp=10", sym_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b_s2_early_done got=%b exp=0", done); end
    step();
    checks++; if (shadow_state !== 2'b10) begin errors++; $display("FAIL b_s2_shadow got=%b exp=10", shadow_state); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b_s2_done got=%b exp=1", done); end
    checks++; if (desync !== 1'b0) begin errors++; $display("FAIL b_s2_desync got=%b exp=0", desync); end
    checks++; if (rx_state !== 2'b10) begin errors++; $display("FAIL b_s2_rx got=%b exp=10", rx_state); end
    step();
  endtask

  task automatic test_same_target();
    req_valid = 1'b1; req_target = 2'd2;
    checks++; if (sym_out !== 2'b10) begin errors++; $display("FAIL same_pre_sym got=%b exp=10", sym_out); end
    step();
    req_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL same_done got=%b exp=1", done); end
    checks++; if (sym_out !== 2'b10) begin errors++; $display("FAIL same_sym got=%b exp=10", sym_out); end
    checks++; if (shadow_state !== 2'b10) begin errors++; $display("FAIL same_shadow got=%b exp=10", shadow_state); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL same_ready got=%b exp=1", req_ready); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL same_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    // S2 -> A on symbol 11 to set up the start state
    req_valid = 1'b1; req_target = 2'd0;
    step();
    req_valid = 1'b0;
    checks++; if (sym_out !== 2'b11) begin errors++; $display("FAIL s2_a_sym got=%b exp=11", sym_out); end
    step();
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL s2_a_shadow got=%b exp=00", shadow_state); end
    step();
    req_valid = 1'b1; req_target = 2'd1;
    step();
    checks++; if (sym_out !== 2'b01) begin errors++; $display("FAIL b2b_sym1 got=%b exp=01", sym_out); end
    step();
    if (done === 1'b1) pulses++;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    checks++; if (shadow_state !== 2'b01) begin errors++; $display("FAIL b2b_mid_shadow got=%b exp=01", shadow_state); end
    req_target = 2'd0;
    step();
    req_valid = 1'b0;
    if (done === 1'b1) pulses++;
    checks++; if (sym_out !== 2'b00) begin errors++; $display("FAIL b2b_sym2 got=%b exp=00", sym_out); end
    step();
    if (done === 1'b1) pulses++;
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL b2b_final_shadow got=%b exp=00", shadow_state); end
    step();
    if (done === 1'b1) pulses++;
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_desync();
    req_valid = 1'b1; req_target = 2'd3;
    step();
    req_valid = 1'b0;
    force_obs = 1'b1; force_val = 1'b0;
    step();
    force_obs = 1'b0;
    checks++; if (desync !== 1'b1) begin errors++; $display("FAIL desync_set got=%b exp=1", desync); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL desync_no_done got=%b exp=0", done); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL desync_ready got=%b exp=0", req_ready); end
    checks++; if (sym_out !== 2'b11) begin errors++; $display("FAIL desync_hold_sym got=%b exp=11", sym_out); end
    checks++; if (dbg_ctrl_state !== 1'b0) begin errors++; $display("FAIL desync_ctrl got=%b exp=0", dbg_ctrl_state); end
    req_valid = 1'b1; req_target = 2'd0;
    step(); step();
    req_valid = 1'b0;
    checks++; if (desync !== 1'b1) begin errors++; $display("FAIL desync_sticky got=%b exp=1", desync); end
    checks++; if (shadow_state !== 2'b11) begin errors++; $display("FAIL desync_shadow got=%b exp=11", shadow_state); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++; if (desync !== 1'b0) begin errors++; $display("FAIL desync_clear got=%b exp=0", desync); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL desync_clear_ready got=%b exp=1", req_ready); end
    checks++; if (shadow_state !== 2'b00) begin errors++; $display("FAIL desync_clear_shadow got=%b exp=00", shadow_state); end
  endtask

  initial begin
    errors = 0; checks = 0;
    force_obs = 1'b0; force_val = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_target = 2'd0;
    test_reset();
    test_single_hop();
    test_two_hop();
    test_same_target();
    test_back_to_back();
    test_desync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
